dp_mem_responder: RTL

- Cache/memory side of datapath_cache_if: answers the datapath's instruction fetches, data loads and data stores from an internal word RAM.
- Answers come back with a configurable wait-state latency as one-cycle ihit/dhit pulses.
- Stands in for the cache/memory hierarchy in datapath-level simulation.
- A preload port lets benches program instruction/data contents before releasing the datapath.

---
 rtl/dp_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/dp_mem_responder.sv
// dp_mem_responder: memory-side responder for the datapath cache interface.
// Serves instruction fetches, data loads and data stores from a word RAM with
// LAT wait states, returning one-cycle ihit/dhit pulses. A preload port lets a
// bench fill the RAM before the datapath starts issuing requests.
module dp_mem_responder #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [31:0]       imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [31:0]       dmemaddr,
  input  logic [31:0]       dmemstore,
  input  logic              halt,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ihit,
  output logic              dhit,
  output logic [31:0]       imemload,
  output logic [31:0]       dmemload,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_NONE, K_IF, K_RD, K_WR} kind_t;

  // Transaction captured at acceptance; later address/data changes are ignored.
  typedef struct packed {
    kind_t             kind;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } req_t;

  state_t            state;
  req_t              req;
  logic [3:0]        cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] iidx, didx;
  logic              req_live, fire, dp_wr;

  // Word index drops the byte offset; upper bits wrap the address space.
  assign iidx = imemaddr[ADDR_W+1:2];
  assign didx = dmemaddr[ADDR_W+1:2];

  logic unused_addr;
  assign unused_addr = ^{imemaddr[31:ADDR_W+2], imemaddr[1:0],
                         dmemaddr[31:ADDR_W+2], dmemaddr[1:0]};

  // The request line that started the transaction must stay high to keep it alive.
  always_comb begin
    req_live = 1'b0;
    case (req.kind)
      K_IF:    req_live = imemREN;
      K_RD:    req_live = dmemREN;
      K_WR:    req_live = dmemWEN;
      default: req_live = 1'b0;
    endcase
  end

  // Last WAIT edge of a live transaction: the response is produced here.
  assign fire  = (state == WAIT) && req_live && (cnt == 4'd0);
  assign dp_wr = fire && (req.kind == K_WR);

  // RAM write port: preload first so a same-word datapath store overrides it.
  always_ff @(posedge CLK) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (dp_wr) mem[req.idx] <= req.data;
  end

  // Request FSM with registered hit, load and busy outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      req      <= '0;
      cnt      <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      busy     <= 1'b0;
      imemload <= '0;
      dmemload <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt && (dmemWEN || dmemREN || imemREN)) begin
            state    <= WAIT;
            busy     <= 1'b1;
            cnt      <= 4'(LAT);
            req.kind <= dmemWEN ? K_WR : (dmemREN ? K_RD : K_IF);
            req.idx  <= (dmemWEN || dmemREN) ? didx : iidx;
            req.data <= dmemstore;
          end
        end
        WAIT: begin
          if (!req_live) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            case (req.kind)
              K_IF: begin
                ihit     <= 1'b1;
                imemload <= mem[req.idx];
              end
              K_RD: begin
                dhit     <= 1'b1;
                dmemload <= mem[req.idx];
              end
              default: dhit <= 1'b1;
            endcase
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
